// File: rtl/seg_scan_mux.sv
// seg_scan_mux: eight-digit scanner for a seven-segment decoder.
// It holds a double-buffered nibble register file and steps sel through
// digits 0..7, holding each digit for DIV cycles. Staged contents are copied
// to the active bank only on the 7->0 step, so a frame never shows a mix of
// old and new digits.
module seg_scan_mux #(
  parameter int DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  output logic [3:0] a,
  output logic [2:0] sel,
  output logic       frame_done,
  output logic       pending
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_sel;
  logic [3:0]    r_stage  [8];
  logic [3:0]    r_active [8];
  state_t        r_state;
  logic          r_pending;
  logic          r_frame_done;

  logic w_step;
  logic w_wrap;
  logic w_apply;

  // A step ends each digit's hold time. A wrap is the step that takes sel
  // from 7 back to 0, i.e. the frame boundary.
  assign w_step  = (r_presc == PRESC_LAST);
  assign w_wrap  = w_step && (r_sel == 3'd7);
  // A commit arriving in the wrap cycle itself applies on that same edge.
  assign w_apply = w_wrap && ((r_state == S_ARMED) || commit);

  assign a          = r_active[r_sel];
  assign sel        = r_sel;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

  // Refresh prescaler, digit index and the frame-boundary pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_sel        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_step) begin
        r_presc <= '0;
        r_sel   <= r_sel + 3'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Staging bank: host writes land here and never touch the display directly
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_stage[i] <= '0;
    end else if (wr_en) begin
      r_stage[wr_addr] <= wr_data;
    end
  end

  // Active bank: whole-frame copy from staging; a same-cycle write is not
  // included because the copy reads the pre-edge staging values
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_active[i] <= '0;
    end else if (w_apply) begin
      for (int i = 0; i < 8; i++) r_active[i] <= r_stage[i];
    end
  end

  // Commit FSM: arm on commit, disarm on the wrap; extra commits while armed
  // are absorbed into the single pending apply
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
    end else if (w_wrap) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
    end else if (commit && (r_state == S_IDLE)) begin
      r_state   <= S_ARMED;
      r_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed testbench for seg_scan_mux with DIV=4 (8 digits x 4 cycles = 32-cycle frame).
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic [3:0] a;
  logic [2:0] sel;
  logic       frame_done;
  logic       pending;

  int n_tests = 0;
  int n_fail  = 0;
  int c       = 0;   // cycles since the last reset edge

  seg_scan_mux #(.DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .a          (a),
    .sel        (sel),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp_v);
    end
  endtask

  // Expected scan position follows directly from the cycle count: sel = (c/4) mod 8.
  task automatic chk_scan(input string tag, input logic [3:0] exp_a);
    logic [7:0] es;
    logic [7:0] ef;
    es = 8'((c / 4) % 8);
    ef = ((c % 32 == 0) && (c != 0)) ? 8'd1 : 8'd0;
    chk({tag, "_sel"}, {5'd0, sel}, es);
    chk({tag, "_a"}, {4'd0, a}, {4'd0, exp_a});
    chk({tag, "_fd"}, {7'd0, frame_done}, ef);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  initial begin
    logic [3:0] ea;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c   = 0;
    chk("rst_sel", {5'd0, sel}, 8'd0);
    chk("rst_a", {4'd0, a}, 8'd0);
    chk("rst_pending", {7'd0, pending}, 8'd0);
    chk("rst_fd", {7'd0, frame_done}, 8'd0);

    // 1: free-running scan with empty display
    for (int i = 0; i < 33; i++) begin
      chk_scan("t1", 4'h0);
      chk("t1_pending", {7'd0, pending}, 8'd0);
      step();
    end

    // 2: stage 1..8, commit at sel=3, applies at the wrap
    for (int s = 0; s < 8; s++) begin
      wr_en = 1'b1; wr_addr = 3'(s); wr_data = 4'(s + 1);
      step();
    end
    wr_en = 1'b0;
    chk_scan("t2_staged", 4'h0);
    while (c < 44) step();
    chk("t2_sel3", {5'd0, sel}, 8'd3);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("t2_armed", {7'd0, pending}, 8'd1);
    chk_scan("t2_armed", 4'h0);
    while (c < 63) step();
    chk("t2_still_armed", {7'd0, pending}, 8'd1);
    chk_scan("t2_prewrap", 4'h0);
    step();
    chk("t2_disarmed", {7'd0, pending}, 8'd0);
    chk_scan("t2_apply", 4'h1);
    for (int i = 0; i < 32; i++) begin
      ea = 4'(((c % 32) / 4) + 1);
      chk_scan("t2_frame", ea);
      step();
    end

    // 3: staging write without commit must not reach the display
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hA;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 96; i++) begin
      ea = 4'(((c % 32) / 4) + 1);
      chk_scan("t3_hold", ea);
      chk("t3_pending", {7'd0, pending}, 8'd0);
      step();
    end

    // 4: commit in the wrap-step cycle from idle applies immediately
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hF;
    step();
    wr_en = 1'b0;
    while (c < 223) step();
    chk("t4_pre_pending", {7'd0, pending}, 8'd0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk_scan("t4_apply", 4'hF);
    chk("t4_pending", {7'd0, pending}, 8'd0);
    while (c < 244) step();
    chk_scan("t4_slot5", 4'hA);

    // 5: commit plus write in the wrap cycle; the copy uses pre-write staging
    while (c < 255) step();
    commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hC;
    step();
    commit = 1'b0; wr_en = 1'b0;
    chk("t5_pending", {7'd0, pending}, 8'd0);
    chk_scan("t5_sel0", 4'hF);
    while (c < 264) step();
    chk_scan("t5_old_slot2", 4'h3);
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("t5_armed", {7'd0, pending}, 8'd1);
    while (c < 288) step();
    chk("t5_disarmed", {7'd0, pending}, 8'd0);
    chk_scan("t5_sel0b", 4'hF);
    while (c < 296) step();
    chk_scan("t5_new_slot2", 4'hC);

    // 6: reset mid-frame aborts a pending commit
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9;
    step();
    wr_en = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("t6_armed", {7'd0, pending}, 8'd1);
    while (c < 304) step();
    chk("t6_sel4", {5'd0, sel}, 8'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    c = 0;
    chk("t6_rst_sel", {5'd0, sel}, 8'd0);
    chk("t6_rst_a", {4'd0, a}, 8'd0);
    chk("t6_rst_pending", {7'd0, pending}, 8'd0);
    chk("t6_rst_fd", {7'd0, frame_done}, 8'd0);
    for (int i = 0; i < 33; i++) begin
      chk_scan("t6_after", 4'h0);
      chk("t6_pending", {7'd0, pending}, 8'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
